// File: rtl/wave_pkg.sv
// rtl/wave_pkg.sv - frame geometry, shared types and the row wave offset used by forward filter and reader
package wave_pkg;
    localparam int FRAME_WIDTH  = 240;
    localparam int FRAME_HEIGHT = 320;
    localparam int FIFO_DEPTH   = 4;

    typedef logic [10:0]        hcount_t;
    typedef logic [9:0]         vcount_t;
    typedef logic [6:0]         pixel_t;
    typedef logic signed [11:0] offset_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        hcount_t hcount;
        vcount_t vcount;
        pixel_t  pixel;
    } beat_t;

    typedef struct packed {
        logic    valid;
        hcount_t hcount;
        vcount_t vcount;
    } tag_t;

    // Horizontal shift applied to row v; the forward filter adds it, the reader subtracts it.
    function automatic offset_t wave_offset(input vcount_t v);
        offset_t vs;
        offset_t a;
        offset_t b;
        vs = $signed({2'b00, v});
        if (vs > offset_t'(FRAME_HEIGHT / 2)) begin
            a = (vs - offset_t'(FRAME_HEIGHT)) >>> 4;
            b = (vs - offset_t'(FRAME_HEIGHT / 2)) >>> 4;
        end else begin
            a = (vs - offset_t'(FRAME_HEIGHT / 2)) >>> 4;
            b = (-vs) >>> 4;
        end
        return a * b;
    endfunction
endpackage

// File: rtl/pix_fifo.sv
// rtl/pix_fifo.sv - 4-entry synchronous beat FIFO with same-cycle push and pop
module pix_fifo
    import wave_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       in_tvalid,
    input  beat_t      in_tdata,
    output logic       out_tvalid,
    input  logic       out_tready,
    output beat_t      out_tdata,
    output logic [2:0] count
);
    beat_t      mem [FIFO_DEPTH];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic       push;
    logic       pop;

    assign out_tvalid = (count != 3'd0);
    assign pop        = out_tvalid && out_tready;
    // Upstream credit keeps a full FIFO from seeing a push; the guard only protects state.
    assign push       = in_tvalid && ((count != 3'(FIFO_DEPTH)) || pop);
    assign out_tdata  = out_tvalid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr] <= in_tdata;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            count <= count + 3'(push) - 3'(pop);
        end
    end
endmodule

// File: rtl/wave_unwarp_reader.sv
// rtl/wave_unwarp_reader.sv - credit-paced raster BRAM reader undoing the row wave (WAVE_UNWARP_EN enables the offset)
module wave_unwarp_reader
    import wave_pkg::*;
#(
    parameter int WIDTH        = FRAME_WIDTH,
    parameter int HEIGHT       = FRAME_HEIGHT,
    parameter int BRAM_LATENCY = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic        ready_in,
    input  logic [6:0]  bram_data_in,
    output logic [16:0] addr_out,
    output logic        rd_en_out,
    output logic        data_valid_out,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic [6:0]  pixel_out,
    output logic        busy_out,
    output logic        frame_done_out
);
    localparam logic signed [12:0] WIDTH_S = 13'(WIDTH);

    state_t             state_q;
    state_t             state_d;
    hcount_t            h_q;
    vcount_t            v_q;
    tag_t               tag_q [BRAM_LATENCY];
    logic [3:0]         in_flight;
    logic [2:0]         fifo_count;
    logic               rd_en;
    logic               last_pos;
    logic               credit_ok;
    logic               frame_done_q;
    offset_t            offset;
    logic signed [12:0] src_raw;
    logic signed [12:0] src_col;
    beat_t              push_beat;
    beat_t              head_beat;
    logic               head_valid;

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < BRAM_LATENCY; i++) begin
            in_flight = in_flight + 4'(tag_q[i].valid);
        end
    end

    // Reads outstanding plus queued beats never exceed the FIFO depth, so pushes cannot overflow.
    assign credit_ok = (4'(fifo_count) + in_flight) < 4'(FIFO_DEPTH);
    assign last_pos  = (h_q == hcount_t'(WIDTH - 1)) && (v_q == vcount_t'(HEIGHT - 1));

    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (credit_ok) begin
                    rd_en = 1'b1;
                    if (last_pos) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((in_flight == 4'd0) && !head_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_done_q <= (state_q == DRAIN) && (state_d == IDLE);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || ((state_q == IDLE) && start_in)) begin
            h_q <= '0;
            v_q <= '0;
        end else if (rd_en) begin
            if (h_q == hcount_t'(WIDTH - 1)) begin
                h_q <= '0;
                v_q <= (v_q == vcount_t'(HEIGHT - 1)) ? '0 : v_q + 10'd1;
            end else begin
                h_q <= h_q + 11'd1;
            end
        end
    end

`ifdef WAVE_UNWARP_EN
    assign offset = wave_offset(v_q);
`else
    assign offset = '0;
`endif

    // The offset magnitude stays below one row, so a single wrap step lands in [0, WIDTH-1].
    always_comb begin
        src_raw = $signed({2'b00, h_q}) - 13'(offset);
        if (src_raw < 13'sd0) begin
            src_col = src_raw + WIDTH_S;
        end else if (src_raw >= WIDTH_S) begin
            src_col = src_raw - WIDTH_S;
        end else begin
            src_col = src_raw;
        end
    end

    assign addr_out  = rd_en ? (17'(v_q) * 17'(WIDTH) + 17'($unsigned(src_col))) : '0;
    assign rd_en_out = rd_en;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < BRAM_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= '{valid: rd_en, hcount: h_q, vcount: v_q};
            for (int i = 1; i < BRAM_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign push_beat = '{hcount: tag_q[BRAM_LATENCY-1].hcount,
                         vcount: tag_q[BRAM_LATENCY-1].vcount,
                         pixel:  bram_data_in};

    pix_fifo u_fifo (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .in_tvalid  (tag_q[BRAM_LATENCY-1].valid),
        .in_tdata   (push_beat),
        .out_tvalid (head_valid),
        .out_tready (ready_in),
        .out_tdata  (head_beat),
        .count      (fifo_count)
    );

    assign data_valid_out = head_valid;
    assign hcount_out     = head_beat.hcount;
    assign vcount_out     = head_beat.vcount;
    assign pixel_out      = head_beat.pixel;
    assign busy_out       = (state_q != IDLE);
    assign frame_done_out = frame_done_q;
endmodule

// File: tb/tb_wave_unwarp_reader.sv
// tb/tb_wave_unwarp_reader.sv - directed self-checking bench for wave_unwarp_reader
module tb_wave_unwarp_reader;
    localparam int W           = 240;
    localparam int H           = 320;
    localparam int FRAME_BEATS = W * H;
    localparam int STALL_AT    = 1000;
    localparam int START_AT    = 3000;

`ifdef WAVE_UNWARP_EN
    localparam int EXP_P0 = 5;
    localparam int EXP_P1 = 19415;
    localparam int EXP_P2 = 57615;
`else
    localparam int EXP_P0 = 5;
    localparam int EXP_P1 = 19200;
    localparam int EXP_P2 = 57830;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        start_in;
    logic        ready_in;
    logic [6:0]  bram_data_in;
    logic [16:0] addr_out;
    logic        rd_en_out;
    logic        data_valid_out;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic [6:0]  pixel_out;
    logic        busy_out;
    logic        frame_done_out;

    logic [6:0]  bram_s1;
    logic [6:0]  bram_s2;

    int vectors     = 0;
    int miscompares = 0;

    int          cyc, beats, issues, bh, bv;
    int          seq_err, addr_err, stall_err, stall_issues;
    int          done_pulses, done_cyc, last_beat_cyc, first_valid_cyc;
    logic [16:0] iq [$];
    logic [16:0] exp_addr;
    logic [16:0] a_p0, a_p1, a_p2;
    logic [27:0] held;
    logic        held_valid;
    logic        found;

    wave_unwarp_reader #(
        .WIDTH        (W),
        .HEIGHT       (H),
        .BRAM_LATENCY (2)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .start_in       (start_in),
        .ready_in       (ready_in),
        .bram_data_in   (bram_data_in),
        .addr_out       (addr_out),
        .rd_en_out      (rd_en_out),
        .data_valid_out (data_valid_out),
        .hcount_out     (hcount_out),
        .vcount_out     (vcount_out),
        .pixel_out      (pixel_out),
        .busy_out       (busy_out),
        .frame_done_out (frame_done_out)
    );

    always #5 clk_in = ~clk_in;

    // Two-cycle BRAM returning the low address bits as pixel data.
    always @(posedge clk_in) begin
        bram_s1 <= addr_out[6:0];
        bram_s2 <= bram_s1;
    end
    assign bram_data_in = bram_s2;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        rst_in   = 1'b1;
        start_in = 1'b0;
        ready_in = 1'b1;
        repeat (3) @(negedge clk_in);
        check("rst_valid",      32'(data_valid_out), 32'(0));
        check("rst_busy",       32'(busy_out),       32'(0));
        check("rst_rd_en",      32'(rd_en_out),      32'(0));
        check("rst_addr",       32'(addr_out),       32'(0));
        check("rst_hcount",     32'(hcount_out),     32'(0));
        check("rst_vcount",     32'(vcount_out),     32'(0));
        check("rst_pixel",      32'(pixel_out),      32'(0));
        check("rst_frame_done", 32'(frame_done_out), 32'(0));

        rst_in = 1'b0;
        @(negedge clk_in);
        check("idle_busy", 32'(busy_out), 32'(0));

        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        check("c1_busy",  32'(busy_out),       32'(1));
        check("c1_rd_en", 32'(rd_en_out),      32'(1));
        check("c1_addr",  32'(addr_out),       32'(0));
        check("c1_valid", 32'(data_valid_out), 32'(0));
        @(negedge clk_in);
        check("c2_valid", 32'(data_valid_out), 32'(0));
        check("c2_addr",  32'(addr_out),       32'(1));
        @(negedge clk_in);
        check("c3_valid", 32'(data_valid_out), 32'(0));
        @(negedge clk_in);
        check("c4_valid",  32'(data_valid_out), 32'(1));
        check("c4_hcount", 32'(hcount_out),     32'(0));
        check("c4_vcount", 32'(vcount_out),     32'(0));
        check("c4_pixel",  32'(pixel_out),      32'(0));

        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk_in);
            if (data_valid_out && (vcount_out == 10'd4)) begin
                found = 1'b1;
            end
        end
        check("reach_row4", 32'(found), 32'(1));

        rst_in = 1'b1;
        @(negedge clk_in);
        check("midrst_busy",  32'(busy_out),       32'(0));
        check("midrst_valid", 32'(data_valid_out), 32'(0));
        check("midrst_rd_en", 32'(rd_en_out),      32'(0));
        check("midrst_addr",  32'(addr_out),       32'(0));
        rst_in = 1'b0;
        @(negedge clk_in);
        check("postrst_busy", 32'(busy_out), 32'(0));

        cyc = 0; beats = 0; issues = 0; bh = 0; bv = 0;
        seq_err = 0; addr_err = 0; stall_err = 0; stall_issues = 0;
        done_pulses = 0; done_cyc = 0; last_beat_cyc = 0; first_valid_cyc = -1;
        a_p0 = '1; a_p1 = '1; a_p2 = '1; held = '0; held_valid = 1'b0;
        start_in = 1'b1;
        while ((cyc < 80000) && !((done_pulses > 0) && (cyc > done_cyc + 4))) begin
            @(negedge clk_in);
            cyc++;
            start_in = (cyc == START_AT);
            ready_in = !((cyc >= STALL_AT) && (cyc < STALL_AT + 10));
            #1;
            if (rd_en_out) begin
                if (issues == 5)          a_p0 = addr_out;
                if (issues == 80 * W)     a_p1 = addr_out;
                if (issues == 240 * W + 230) a_p2 = addr_out;
`ifndef WAVE_UNWARP_EN
                if (addr_out !== 17'(issues)) addr_err++;
`endif
                iq.push_back(addr_out);
                issues++;
                if ((cyc >= STALL_AT) && (cyc < STALL_AT + 10)) stall_issues++;
            end
            if (cyc == STALL_AT) begin
                held_valid = data_valid_out;
                held       = {hcount_out, vcount_out, pixel_out};
            end else if ((cyc > STALL_AT) && (cyc < STALL_AT + 10)) begin
                if ((data_valid_out !== 1'b1) || ({hcount_out, vcount_out, pixel_out} !== held)) stall_err++;
            end
            if (data_valid_out && (first_valid_cyc < 0)) first_valid_cyc = cyc;
            if (data_valid_out && ready_in) begin
                if (iq.size() == 0) begin
                    seq_err++;
                    exp_addr = '0;
                end else begin
                    exp_addr = iq.pop_front();
                end
                if ((hcount_out !== 11'(bh)) || (vcount_out !== 10'(bv)) || (pixel_out !== exp_addr[6:0])) seq_err++;
                beats++;
                last_beat_cyc = cyc;
                if (bh == W - 1) begin
                    bh = 0;
                    bv++;
                end else begin
                    bh++;
                end
            end
            if (frame_done_out) begin
                done_pulses++;
                if (done_pulses == 1) done_cyc = cyc;
            end
        end

        check("frame_beats",     32'(beats),           32'(FRAME_BEATS));
        check("frame_issues",    32'(issues),          32'(FRAME_BEATS));
        check("beat_sequence",   32'(seq_err),         32'(0));
        check("first_valid_cyc", 32'(first_valid_cyc), 32'(4));
        check("done_pulses",     32'(done_pulses),     32'(1));
        check("done_after_last", 32'(done_cyc - last_beat_cyc), 32'(2));
        check("stall_valid",     32'(held_valid),      32'(1));
        check("stall_hold",      32'(stall_err),       32'(0));
        check("stall_issues",    32'(stall_issues <= 4), 32'(1));
        check("addr_h5_v0",      32'(a_p0),            32'(EXP_P0));
        check("addr_h0_v80",     32'(a_p1),            32'(EXP_P1));
        check("addr_h230_v240",  32'(a_p2),            32'(EXP_P2));
`ifndef WAVE_UNWARP_EN
        check("raster_addr",     32'(addr_err),        32'(0));
`endif
        check("end_busy",        32'(busy_out),        32'(0));
        check("end_queue",       32'(iq.size()),       32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/wave_unwarp_reader.md
WAVE_UNWARP_READER -- requirements
Module: wave_unwarp_reader

Interface
REQ-001 Parameter WIDTH, default 240: frame columns.
REQ-002 Parameter HEIGHT, default 320: frame rows.
REQ-003 Parameter BRAM_LATENCY, default 2: cycles from addr_out/rd_en_out to valid bram_data_in.
REQ-004 clk_in  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-005 rst_in  input  1  reset; synchronous, active-high.
REQ-006 start_in  input  1  frame-start pulse.
REQ-007 ready_in  input  1  downstream accepts the current beat.
REQ-008 bram_data_in  input  7  pixel returned by the frame-buffer BRAM.
REQ-009 addr_out  output  17  BRAM read address, row*WIDTH+col.
REQ-010 rd_en_out  output  1  read issued this cycle.
REQ-011 data_valid_out  output  1  beat valid.
REQ-012 hcount_out  output  11  output column of beat.
REQ-013 vcount_out  output  10  output row of beat.
REQ-014 pixel_out  output  7  pixel of beat.
REQ-015 busy_out  output  1  high when not IDLE.
REQ-016 frame_done_out  output  1  one-cycle end-of-frame pulse.

Function
REQ-017 FSM states IDLE, SCAN, DRAIN.
REQ-018 IDLE->SCAN when start_in is high; raster counters (h,v) cleared to (0,0); start_in outside IDLE SHALL be ignored.
REQ-019 SCAN issues at most one read per cycle in raster order (h fastest), only when FIFO occupancy plus in-flight reads < 4.
REQ-020 Offset per row, signed 12-bit, arithmetic shifts: v>160: ((v-320)>>>4)*((v-160)>>>4); else ((v-160)>>>4)*((-v)>>>4).
REQ-021 Source column = (h - offset) mod WIDTH, always in [0,WIDTH-1]; addr_out = v*WIDTH + source column.
REQ-022 After the read for (WIDTH-1,HEIGHT-1) is issued: SCAN->DRAIN.
REQ-023 DRAIN->IDLE when in-flight=0 and FIFO empty; frame_done_out SHALL pulse in the cycle IDLE is re-entered.
REQ-024 bram_data_in SHALL be captured exactly BRAM_LATENCY cycles after its rd_en_out, with its (h,v) carried in a matching tag pipeline, and pushed into the FIFO.
REQ-025 data_valid_out = FIFO non-empty; a beat SHALL pop on data_valid_out && ready_in; hcount_out/vcount_out/pixel_out SHALL hold while valid && !ready_in.
REQ-026 Credit rule (REQ-019) SHALL guarantee the FIFO never overflows; no beat lost or duplicated.
REQ-027 First data_valid_out SHALL assert BRAM_LATENCY+2 cycles after the start_in cycle when unstalled.
REQ-028 With ready_in held high, throughput SHALL be one beat per cycle.

Reset
REQ-029 rst_in SHALL force IDLE, clear counters, in-flight pipeline and FIFO, and drive every output to 0 on the next edge, including mid-frame.

Configuration
REQ-030 Macro WAVE_UNWARP_EN defined: offset per REQ-020; undefined: offset SHALL be 0 (straight raster readout), all else identical.

Structure
REQ-031 Package wave_pkg SHALL hold WIDTH/HEIGHT constants, state enum, coordinate typedefs and the offset function shared with the forward wave filter.
REQ-032 One sub-module pix_fifo: 4-entry synchronous FIFO of {hcount,vcount,pixel}.

Verification
REQ-033 Reset: rst_in high 3 cycles -> all outputs 0, busy_out 0.
REQ-034 Macro off, ready_in=1, BRAM model returns addr[6:0]: 76800 beats in raster order, first at cycle 4 after start with pixel 0, frame_done_out single pulse after last beat.
REQ-035 Macro on: (h=0,v=80) -> addr_out 19415; (h=230,v=240) -> addr_out 57615; (h=5,v=0) -> addr_out 5.
REQ-036 ready_in low 10 cycles mid-frame -> rd_en_out stops within 4 issues, outputs stable, sequence resumes with no gap/duplicate.
REQ-037 rst_in mid-frame at v=100 -> IDLE next cycle, valid 0; subsequent start_in restarts at (0,0).
REQ-038 start_in pulsed during SCAN -> ignored; exactly 76800 beats and one frame_done_out.
